bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential binary-to-BCD converter that feeds the four-digit seven-segment display driver. It accepts an unsigned binary value on a start pulse and runs an iterative shift-and-add-3 (double-dabble) conversion. It then presents four packed BCD digits on a registered `bcd_out[15:0]` that stays stable between conversions, so the display never shows intermediate values. Values above 9999 saturate to 9999 and raise an overflow flag.

## Interface
- `BIN_W`, default 14: width of the binary input; legal range 4..14.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `bin_in`  in  BIN_W  unsigned value; sampled only on the accepting edge.
- `start`  in  1  conversion request; single-cycle pulse or level.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `bcd_out` and `overflow` are valid from this cycle.
- `overflow`  out  1  last accepted `bin_in` exceeded 9999; held until the next result.
- `bcd_out`  out  16  digits {thousands, hundreds, tens, ones}; drives the display driver's BCD input directly.

## Operation
- States:
  - IDLE: wait for start.
  - SHIFT: iterate.
- IDLE, `start`=1 → SHIFT:
  - Load the shift register with {16'b0, `bin_in`}.
  - Load the iteration counter with BIN_W-1.
  - Latch `ovf_pend` = (`bin_in` > 9999).
- SHIFT, each edge:
  - For each of the 4 BCD nibbles of the current register value, add 3 if the nibble ≥ 5.
  - Shift the whole register left by 1.
  - Decrement the counter.
- SHIFT, counter = 0 (final shift) → IDLE:
  - `bcd_out` ← shifted BCD field, or 16'h9999 if `ovf_pend`.
  - `overflow` ← `ovf_pend`.
  - `done` ← 1 for exactly one cycle.
- `start` outside IDLE is ignored and not queued.
- `bcd_out` and `overflow` change only on a `done` edge or on reset. During SHIFT they keep the previous result.
- Arithmetic: the internal register is 16+BIN_W bits. Nibble adjust results are truncated to 4 bits; the add-3 rule guarantees this never loses data for values ≤ 9999. Saturation covers larger values, where thousands-digit carries are discarded.
- For BIN_W < 14, `overflow` is constant 0. The comparator may be optimised away, but the port remains.

## Timing
- Reset (`rst_n`=0, asynchronous): state IDLE, `busy`=0, `done`=0, `overflow`=0, `bcd_out`=16'h0000, counter 0, shift register 0.
- Reset mid-conversion aborts: no `done`, and `bcd_out` returns to 0.
- Release is synchronous to `clk`. The first `start` is accepted on the first rising edge with `rst_n`=1.
- Latency, with `start` accepted at edge E:
  - `busy`=1 after edge E through edge E+BIN_W−1 (BIN_W cycles).
  - `done`=1 and new `bcd_out` after edge E+BIN_W.
  - Default BIN_W=14: result 14 cycles after acceptance.
- Back-to-back: `start` held high is re-accepted on edge E+BIN_W+1, the cycle in which `done` is high. Throughput is one conversion per BIN_W+1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `seg_pkg`:
  - `BCD_DIGITS`=4, `BCD_W`=16, `BCD_MAX`=9999, `BCD_SAT`=16'h9999.
  - FSM state typedef {IDLE, SHIFT}.
  - The display driver uses the same package for its digit count.
- One natural sub-module: `bcd_digit_adj`, purely combinational (4-bit in → 4-bit out, +3 when ≥5), instantiated once per digit.

## Test plan
- Reset: assert `rst_n`=0 mid-SHIFT → `bcd_out`=16'h0000, `busy`=0, `done`=0 immediately, asynchronous to `clk`; no `done` pulse after release.
- Single conversion: `bin_in`=1234, one-cycle `start` → `busy` high 14 cycles, `done` one cycle later, `bcd_out`=16'h1234, `overflow`=0.
- Boundaries: 0 → 16'h0000; 9 → 16'h0009; 10 → 16'h0010; 9999 → 16'h9999 with `overflow`=0.
- Saturation: `bin_in`=10000 → 16'h9999, `overflow`=1; next `bin_in`=42 → 16'h0042, `overflow`=0.
- Ignored start and hold: issue `start` with `bin_in`=5678, then `start` again with 1111 while busy → result 16'h5678. `bcd_out` holds the old value throughout SHIFT.
- Back-to-back: `start` held high with `bin_in` alternating 0/9999 each accept → `done` every 15 cycles, results alternate correctly.
- Exhaustive sweep: all values 0..16383 checked against a reference model.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the BCD converter and the seven-segment display driver.
package seg_pkg;
  localparam int          BCD_DIGITS = 4;
  localparam int          BCD_W      = 16;
  localparam int          BCD_MAX    = 9999;
  localparam logic [15:0] BCD_SAT    = 16'h9999;

  typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 when the nibble is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  // Result is truncated to 4 bits; it only wraps for saturated inputs.
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary to 4-digit BCD converter, saturating at 9999.
module bin_to_bcd_seq
  import seg_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [BCD_W-1:0] bcd_out
);
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [SR_W-1:0]    sr_adj, sr_shift;
  logic               in_ovf;

  // One corrector per BCD digit, acting on the upper field of the shift register.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (sr_q[BIN_W + 4*g +: 4]),
      .d_o (bcd_adj[4*g +: 4])
    );
  end

  assign sr_adj   = {bcd_adj, sr_q[BIN_W-1:0]};
  assign sr_shift = {sr_adj[SR_W-2:0], 1'b0};

  // Narrow inputs cannot exceed 9999, so the comparator is only built at full width.
  if (BIN_W >= 14) begin : g_ovf
    assign in_ovf = (32'(bin_in) > 32'(BCD_MAX));
  end else begin : g_no_ovf
    assign in_ovf = 1'b0;
  end

  // Next-state logic: accept in IDLE, iterate in SHIFT, publish on the final shift.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          sr_d       = {{BCD_W{1'b0}}, bin_in};
          cnt_d      = CNT_W'(BIN_W - 1);
          ovf_pend_d = in_ovf;
        end
      end
      SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          bcd_d   = ovf_pend_q ? BCD_SAT : sr_shift[BIN_W +: BCD_W];
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears everything including any result in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign bcd_out  = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq with a decimal reference model.
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] bin_in;
  logic        start;
  logic        busy, done, overflow;
  logic [15:0] bcd_out;

  int n_chk  = 0;
  int n_pass = 0;

  bin_to_bcd_seq #(.BIN_W(14)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bin_in   (bin_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd_out  (bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Decimal digit extraction, independent of the shift-and-add method.
  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // One conversion from IDLE; optionally fires a second start while busy.
  task automatic convert(input int v, input bit inject);
    logic [15:0] old;
    int n, bcnt;
    bit hold_ok;
    old     = bcd_out;
    bin_in  = 14'(v);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    bcnt    = busy ? 1 : 0;
    hold_ok = 1'b1;
    n       = 0;
    do begin
      if (inject && n == 3) begin bin_in = 14'd1111; start = 1'b1; end
      if (inject && n == 4) start = 1'b0;
      @(posedge clk); #1;
      n++;
      if (!done) begin
        if (busy) bcnt++;
        if (bcd_out !== old) hold_ok = 1'b0;
      end
    end while (!done && n < 40);
    chk($sformatf("lat[%0d]", v), n, 14);
    chk($sformatf("busy[%0d]", v), bcnt, 14);
    chk($sformatf("hold[%0d]", v), {31'd0, hold_ok}, 1);
    chk($sformatf("bcd[%0d]", v), bcd_out, inject ? 16'h5678 : ref_bcd(v));
    chk($sformatf("ovf[%0d]", v), overflow, (v > 9999) ? 1 : 0);
  endtask

  initial begin
    int vals[8];
    int n;
    bit seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    #12;
    chk("rst_bcd", bcd_out, 16'h0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk); rst_n = 1'b1;

    // Single conversion, then done must drop after one cycle.
    convert(1234, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("bcd_keep", bcd_out, 16'h1234);

    convert(0, 1'b0);
    convert(9, 1'b0);
    convert(10, 1'b0);
    convert(9999, 1'b0);
    convert(10000, 1'b0);
    convert(42, 1'b0);
    convert(16383, 1'b0);
    convert(5678, 1'b1);

    // Back-to-back with start held: one result every 15 cycles.
    for (int i = 0; i < 8; i++) vals[i] = (i % 2) ? 9999 : 0;
    bin_in = 14'(vals[0]);
    start  = 1'b1;
    @(posedge clk); #1;
    bin_in = 14'(vals[1]);
    for (int k = 0; k < 6; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done && n < 40);
      chk($sformatf("b2b_lat%0d", k), n, 14);
      chk($sformatf("b2b_bcd%0d", k), bcd_out, ref_bcd(vals[k]));
      @(posedge clk); #1;
      chk($sformatf("b2b_acc%0d", k), busy, 1);
      bin_in = 14'(vals[k + 2]);
    end
    start = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 40);
    chk("b2b_drain", bcd_out, ref_bcd(vals[6]));

    // Asynchronous reset in the middle of a conversion.
    bin_in = 14'd4321;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_bcd", bcd_out, 16'h0000);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
    chk("arst_quiet", {31'd0, seen}, 0);

    // Strided sweep plus the saturation edge.
    for (int v = 0; v < 16384; v += 13) convert(v, 1'b0);
    for (int v = 9995; v <= 10005; v++) convert(v, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
